// File: rtl/mem_ctrl_pkg.sv
// Shared types for the data-memory access controller.
// Memory words are big-endian: lane 0 holds bits 31:24.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } mem_size_t;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR,
    RMW_RD,
    RMW_WR,
    RESP
  } mac_state_t;

  typedef logic [0:3][7:0] mem_word_t;

  localparam int DEFAULT_MEM_LATENCY = 4;

endpackage

// File: rtl/mem_lane_unit.sv
// Byte-lane datapath: load extract/extend, store merge,
// and misalignment detection.
module mem_lane_unit
  import mem_ctrl_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        is_unsigned,
  input  logic [15:0] wdata,
  input  mem_word_t   rword,
  output logic        misaligned,
  output logic [31:0] load_data,
  output mem_word_t   merged
);

  logic [7:0]  b;
  logic [15:0] h;
  logic        is_b;
  logic        is_h;
  logic        is_w;

  assign is_b = size == SZ_BYTE;
  assign is_h = size == SZ_HALF;
  assign is_w = size == SZ_WORD;

  assign b = rword[addr_lo];
  assign h = addr_lo[1] ? {rword[2], rword[3]}
                        : {rword[0], rword[1]};

  // size 11 has no legal alignment
  assign misaligned = (is_h & addr_lo[0])
                    | (is_w & (|addr_lo))
                    | (size == 2'b11);

  always_comb begin
    load_data = rword;
    unique case (1'b1)
      is_b: load_data = {{24{b[7] & ~is_unsigned}}, b};
      is_h: load_data = {{16{h[15] & ~is_unsigned}}, h};
      default: ;
    endcase
  end

  always_comb begin
    merged = rword;
    unique case (1'b1)
      is_b: merged[addr_lo] = wdata[7:0];
      is_h: begin
        merged[{addr_lo[1], 1'b0}] = wdata[15:8];
        merged[{addr_lo[1], 1'b1}] = wdata[7:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Serialising load/store controller in front of a
// latency-delayed word memory; sub-word stores use RMW.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int LATENCY = DEFAULT_MEM_LATENCY
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        core_stall,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata,
  output logic [31:0] mem_addr,
  output mem_word_t   mem_data_in,
  output logic        mem_write_en,
  input  mem_word_t   mem_data_out
);

  localparam logic [3:0] LAT_C = 4'(LATENCY);

  mac_state_t  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [1:0]  alo_q, alo_d;
  logic [15:0] wdata_q, wdata_d;
  logic [31:0] maddr_q, maddr_d;
  mem_word_t   mdata_q, mdata_d;
  logic        mwe_q, mwe_d;
  logic        rvalid_q, rvalid_d;
  logic        rerr_q, rerr_d;
  logic [31:0] rdata_q, rdata_d;

  logic        idle;
  logic [1:0]  lane_size;
  logic [1:0]  lane_alo;
  logic        misaligned;
  logic [31:0] load_data;
  mem_word_t   merged;

  // Alignment is judged on the live request, extraction on the latch
  assign idle      = state_q == IDLE;
  assign lane_size = idle ? req_size : size_q;
  assign lane_alo  = idle ? req_addr[1:0] : alo_q;

  mem_lane_unit u_lane (
    .size        (lane_size),
    .addr_lo     (lane_alo),
    .is_unsigned (uns_q),
    .wdata       (wdata_q),
    .rword       (mem_data_out),
    .misaligned  (misaligned),
    .load_data   (load_data),
    .merged      (merged)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    size_d   = size_q;
    uns_d    = uns_q;
    alo_d    = alo_q;
    wdata_d  = wdata_q;
    maddr_d  = maddr_q;
    mdata_d  = mdata_q;
    mwe_d    = 1'b0;
    rvalid_d = 1'b0;
    rerr_d   = 1'b0;
    rdata_d  = '0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          size_d  = req_size;
          uns_d   = req_unsigned;
          alo_d   = req_addr[1:0];
          wdata_d = req_wdata[15:0];
          cnt_d   = '0;
          if (misaligned) begin
            state_d  = RESP;
            rvalid_d = 1'b1;
            rerr_d   = 1'b1;
          end else begin
            maddr_d = {req_addr[31:2], 2'b00};
            if (!req_we) begin
              state_d = RD;
            end else if (req_size == SZ_WORD) begin
              state_d = WR;
              mwe_d   = 1'b1;
              mdata_d = req_wdata;
            end else begin
              state_d = RMW_RD;
            end
          end
        end
      end
      RD, RMW_RD: begin
        if (cnt_q == LAT_C) begin
          cnt_d = '0;
          if (state_q == RD) begin
            state_d  = RESP;
            rvalid_d = 1'b1;
            rdata_d  = load_data;
          end else begin
            state_d = RMW_WR;
            mwe_d   = 1'b1;
            mdata_d = merged;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      WR, RMW_WR: begin
        if (cnt_q == LAT_C) begin
          state_d  = RESP;
          rvalid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      size_q   <= '0;
      uns_q    <= 1'b0;
      alo_q    <= '0;
      wdata_q  <= '0;
      maddr_q  <= '0;
      mdata_q  <= '0;
      mwe_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rerr_q   <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      size_q   <= size_d;
      uns_q    <= uns_d;
      alo_q    <= alo_d;
      wdata_q  <= wdata_d;
      maddr_q  <= maddr_d;
      mdata_q  <= mdata_d;
      mwe_q    <= mwe_d;
      rvalid_q <= rvalid_d;
      rerr_q   <= rerr_d;
      rdata_q  <= rdata_d;
    end
  end

  assign core_stall   = req_valid & ~rvalid_q;
  assign rsp_valid    = rvalid_q;
  assign rsp_err      = rerr_q;
  assign rsp_rdata    = rdata_q;
  assign mem_addr     = maddr_q;
  assign mem_data_in  = mdata_q;
  assign mem_write_en = mwe_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl with a delayed word memory model.
// Expected responses are queued from a byte-level model.
module tb_mem_access_ctrl;
  import mem_ctrl_pkg::*;

  localparam int L = 4;

  typedef struct packed {
    logic        we;
    logic [1:0]  sz;
    logic        u;
    logic [31:0] a;
    logic [31:0] wd;
  } op_t;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
    logic [7:0]  lat;
    logic [3:0]  wes;
  } rsp_t;

  logic            clk = 1'b0;
  logic            rst_b = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_we = 1'b0;
  logic [1:0]      req_size = 2'b00;
  logic            req_unsigned = 1'b0;
  logic [31:0]     req_addr = '0;
  logic [31:0]     req_wdata = '0;
  logic            core_stall, rsp_valid, rsp_err, mem_write_en;
  logic [31:0]     rsp_rdata, mem_addr;
  logic [0:3][7:0] mem_data_in, mem_data_out;

  logic [31:0] mem [0:255];
  logic [31:0] rd_pipe [0:L-1];
  logic [31:0] wd_pipe [0:L-1];
  logic        we_pipe [0:L-1];
  logic        pl_en = 1'b0;
  logic [7:0]  pl_idx = '0;
  logic [31:0] pl_data = '0;

  rsp_t exp_q[$];
  int   tests_run = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.LATENCY(L)) dut (
    .clk          (clk),
    .rst_b        (rst_b),
    .req_valid    (req_valid),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .core_stall   (core_stall),
    .rsp_valid    (rsp_valid),
    .rsp_err      (rsp_err),
    .rsp_rdata    (rsp_rdata),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_write_en (mem_write_en),
    .mem_data_out (mem_data_out)
  );

  // Memory: read data, write data and strobe pass through L-deep chains
  assign mem_data_out = rd_pipe[L-1];

  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < L; i++) begin
        rd_pipe[i] <= '0;
        wd_pipe[i] <= '0;
        we_pipe[i] <= 1'b0;
      end
    end else begin
      rd_pipe[0] <= mem[mem_addr[9:2]];
      wd_pipe[0] <= mem_data_in;
      we_pipe[0] <= mem_write_en;
      for (int i = 1; i < L; i++) begin
        rd_pipe[i] <= rd_pipe[i-1];
        wd_pipe[i] <= wd_pipe[i-1];
        we_pipe[i] <= we_pipe[i-1];
      end
    end
  end

  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_data;
    else if (we_pipe[L-1]) mem[mem_addr[9:2]] <= wd_pipe[L-1];
  end

  function automatic logic misal(logic [1:0] sz, logic [31:0] a);
    return (sz == 2'b11) || (sz == 2'b01 && a[0])
        || (sz == 2'b10 && a[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] m_load(logic [31:0] w, op_t op);
    int sh;
    logic [31:0] v;
    v = w;
    if (op.sz == 2'b00) begin
      sh = 8 * (3 - int'(op.a[1:0]));
      v = (w >> sh) & 32'hFF;
      if (!op.u && v[7]) v = v | 32'hFFFF_FF00;
    end else if (op.sz == 2'b01) begin
      sh = op.a[1] ? 0 : 16;
      v = (w >> sh) & 32'hFFFF;
      if (!op.u && v[15]) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  function automatic logic [31:0] m_store(logic [31:0] w, op_t op);
    int sh;
    logic [31:0] m;
    if (misal(op.sz, op.a) || !op.we) return w;
    if (op.sz == 2'b10) return op.wd;
    if (op.sz == 2'b00) begin
      sh = 8 * (3 - int'(op.a[1:0]));
      m = 32'hFF << sh;
    end else begin
      sh = op.a[1] ? 0 : 16;
      m = 32'hFFFF << sh;
    end
    return (w & ~m) | ((op.wd << sh) & m);
  endfunction

  function automatic rsp_t model_rsp(op_t op, logic [31:0] old);
    rsp_t r;
    r.err   = misal(op.sz, op.a);
    r.rdata = (r.err || op.we) ? 32'h0 : m_load(old, op);
    if (r.err) r.lat = 8'd1;
    else if (!op.we || op.sz == 2'b10) r.lat = 8'(L + 2);
    else r.lat = 8'(2 * L + 3);
    r.wes = (op.we && !r.err) ? 4'd1 : 4'd0;
    return r;
  endfunction

  task automatic poke(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1;
    pl_idx = a[9:2];
    pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Drives one request; reports response, latency, strobe count
  // and how many busy cycles had a wrong mem_addr or core_stall.
  task automatic issue(input op_t op, output rsp_t obs, output int bad);
    int k;
    obs = '0;
    bad = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_we = op.we;
    req_size = op.sz;
    req_unsigned = op.u;
    req_addr = op.a;
    req_wdata = op.wd;
    k = 0;
    obs.lat = 8'hFF;
    while (k < 200) begin
      @(negedge clk);
      k++;
      if (mem_write_en) obs.wes = obs.wes + 4'd1;
      if (rsp_valid) begin
        obs.err = rsp_err;
        obs.rdata = rsp_rdata;
        obs.lat = 8'(k);
        if (core_stall !== 1'b0) bad++;
        break;
      end
      if (mem_addr !== {op.a[31:2], 2'b00}) bad++;
      if (core_stall !== 1'b1) bad++;
    end
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    int hi;
    tests_run++;
    if ({rsp_valid, rsp_err, rsp_rdata, mem_addr, mem_data_in,
         mem_write_en, core_stall} !== '0) begin
      fails++;
      $display("FAIL reset_outputs got v=%0b e=%0b d=%h a=%h w=%0b",
               rsp_valid, rsp_err, rsp_rdata, mem_addr, mem_write_en);
    end
    poke(32'h200, 32'h5555_5555);
    @(negedge clk);
    req_valid = 1'b1;
    req_we = 1'b1;
    req_size = 2'b10;
    req_addr = 32'h200;
    req_wdata = 32'h1234_5678;
    @(negedge clk);
    @(negedge clk);
    rst_b = 1'b0;
    req_valid = 1'b0;
    #1;
    tests_run++;
    if ({rsp_valid, rsp_err, rsp_rdata, mem_addr, mem_data_in,
         mem_write_en, core_stall} !== '0) begin
      fails++;
      $display("FAIL midrun_reset got v=%0b a=%h w=%0b d=%h want all 0",
               rsp_valid, mem_addr, mem_write_en, mem_data_in);
    end
    @(negedge clk);
    rst_b = 1'b1;
    hi = 0;
    repeat (L + 3) begin
      @(negedge clk);
      if (mem_write_en) hi++;
    end
    tests_run++;
    if (hi != 0) begin
      fails++;
      $display("FAIL post_reset_we got %0d strobes want 0", hi);
    end
    tests_run++;
    if (mem[8'h80] !== 32'h5555_5555) begin
      fails++;
      $display("FAIL reset_discard got %h want 55555555", mem[8'h80]);
    end
  endtask

  task automatic test_load_word();
    op_t op;
    rsp_t obs, exp;
    int bad;
    poke(32'h100, 32'hDEAD_BEEF);
    op = '{1'b0, 2'b10, 1'b0, 32'h100, 32'h0};
    exp_q.push_back(model_rsp(op, mem[8'h40]));
    issue(op, obs, bad);
    exp = exp_q.pop_front();
    tests_run++;
    if (obs !== exp || bad != 0) begin
      fails++;
      $display("FAIL lw_100 got e=%0b d=%h lat=%0d we=%0d bad=%0d want e=%0b d=%h lat=%0d we=%0d",
               obs.err, obs.rdata, obs.lat, obs.wes, bad,
               exp.err, exp.rdata, exp.lat, exp.wes);
    end
  endtask

  task automatic test_subword_store();
    op_t ops [3];
    rsp_t obs, exp;
    logic [31:0] old;
    int bad;
    ops = '{'{1'b1, 2'b00, 1'b0, 32'h101, 32'h0000_00AA},
            '{1'b1, 2'b01, 1'b0, 32'h102, 32'h0000_BEEF},
            '{1'b1, 2'b00, 1'b0, 32'h103, 32'hFFFF_FF5A}};
    poke(32'h100, 32'h1122_3344);
    for (int i = 0; i < 3; i++) begin
      old = mem[ops[i].a[9:2]];
      exp_q.push_back(model_rsp(ops[i], old));
      issue(ops[i], obs, bad);
      exp = exp_q.pop_front();
      tests_run++;
      if (obs !== exp || bad != 0) begin
        fails++;
        $display("FAIL store[%0d] got e=%0b d=%h lat=%0d we=%0d bad=%0d want e=%0b d=%h lat=%0d we=%0d",
                 i, obs.err, obs.rdata, obs.lat, obs.wes, bad,
                 exp.err, exp.rdata, exp.lat, exp.wes);
      end
      tests_run++;
      if (mem[ops[i].a[9:2]] !== m_store(old, ops[i])) begin
        fails++;
        $display("FAIL store_mem[%0d] got %h want %h",
                 i, mem[ops[i].a[9:2]], m_store(old, ops[i]));
      end
    end
  endtask

  task automatic test_load_ext();
    op_t ops [6];
    rsp_t obs, exp;
    int bad;
    ops = '{'{1'b0, 2'b01, 1'b0, 32'h102, 32'h0},
            '{1'b0, 2'b01, 1'b1, 32'h102, 32'h0},
            '{1'b0, 2'b00, 1'b0, 32'h100, 32'h0},
            '{1'b0, 2'b00, 1'b0, 32'h102, 32'h0},
            '{1'b0, 2'b00, 1'b1, 32'h103, 32'h0},
            '{1'b0, 2'b01, 1'b0, 32'h100, 32'h0}};
    poke(32'h100, 32'h1122_F344);
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(model_rsp(ops[i], mem[ops[i].a[9:2]]));
      issue(ops[i], obs, bad);
      exp = exp_q.pop_front();
      tests_run++;
      if (obs !== exp || bad != 0) begin
        fails++;
        $display("FAIL load[%0d] got e=%0b d=%h lat=%0d we=%0d bad=%0d want e=%0b d=%h lat=%0d we=%0d",
                 i, obs.err, obs.rdata, obs.lat, obs.wes, bad,
                 exp.err, exp.rdata, exp.lat, exp.wes);
      end
    end
  endtask

  task automatic test_misaligned();
    op_t ops [4];
    rsp_t obs, exp;
    logic [31:0] old;
    int bad;
    ops = '{'{1'b0, 2'b10, 1'b0, 32'h102, 32'h0},
            '{1'b1, 2'b01, 1'b0, 32'h101, 32'h0000_7777},
            '{1'b1, 2'b11, 1'b0, 32'h100, 32'h8888_8888},
            '{1'b1, 2'b10, 1'b0, 32'h103, 32'h9999_9999}};
    for (int i = 0; i < 4; i++) begin
      old = mem[ops[i].a[9:2]];
      exp_q.push_back(model_rsp(ops[i], old));
      issue(ops[i], obs, bad);
      exp = exp_q.pop_front();
      tests_run++;
      if (obs !== exp || bad != 0) begin
        fails++;
        $display("FAIL misal[%0d] got e=%0b d=%h lat=%0d we=%0d bad=%0d want e=%0b d=%h lat=%0d we=%0d",
                 i, obs.err, obs.rdata, obs.lat, obs.wes, bad,
                 exp.err, exp.rdata, exp.lat, exp.wes);
      end
      repeat (L + 1) @(negedge clk);
      tests_run++;
      if (mem[ops[i].a[9:2]] !== old) begin
        fails++;
        $display("FAIL misal_mem[%0d] got %h want %h",
                 i, mem[ops[i].a[9:2]], old);
      end
    end
  endtask

  task automatic test_back_to_back();
    op_t ops [4];
    rsp_t obs, exp;
    int bad;
    ops = '{'{1'b1, 2'b10, 1'b0, 32'h104, 32'hCAFE_F00D},
            '{1'b0, 2'b10, 1'b0, 32'h104, 32'h0},
            '{1'b1, 2'b01, 1'b0, 32'h104, 32'h0000_8001},
            '{1'b0, 2'b01, 1'b0, 32'h104, 32'h0}};
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(model_rsp(ops[i], mem[ops[i].a[9:2]]));
      issue(ops[i], obs, bad);
      exp = exp_q.pop_front();
      tests_run++;
      if (obs !== exp || bad != 0) begin
        fails++;
        $display("FAIL b2b[%0d] got e=%0b d=%h lat=%0d we=%0d bad=%0d want e=%0b d=%h lat=%0d we=%0d",
                 i, obs.err, obs.rdata, obs.lat, obs.wes, bad,
                 exp.err, exp.rdata, exp.lat, exp.wes);
      end
    end
  endtask

  task automatic test_reset_rmw();
    op_t op;
    rsp_t obs;
    int k, bad;
    poke(32'h108, 32'h0102_0304);
    @(negedge clk);
    req_valid = 1'b1;
    req_we = 1'b1;
    req_size = 2'b00;
    req_addr = 32'h109;
    req_wdata = 32'h0000_0077;
    k = 0;
    while (k < 50 && !mem_write_en) begin
      @(negedge clk);
      k++;
    end
    tests_run++;
    if (k != L + 2) begin
      fails++;
      $display("FAIL rmw_we_cycle got %0d want %0d", k, L + 2);
    end
    @(negedge clk);
    rst_b = 1'b0;
    req_valid = 1'b0;
    #1;
    tests_run++;
    if ({mem_write_en, rsp_valid, mem_addr} !== '0) begin
      fails++;
      $display("FAIL rmw_reset got we=%0b v=%0b a=%h want 0",
               mem_write_en, rsp_valid, mem_addr);
    end
    @(negedge clk);
    rst_b = 1'b1;
    repeat (L + 3) @(negedge clk);
    tests_run++;
    if (mem[8'h42] !== 32'h0102_0304) begin
      fails++;
      $display("FAIL rmw_discard got %h want 01020304", mem[8'h42]);
    end
    op = '{1'b0, 2'b10, 1'b0, 32'h108, 32'h0};
    issue(op, obs, bad);
    tests_run++;
    if (obs.rdata !== 32'h0102_0304 || obs.lat != 8'(L + 2)) begin
      fails++;
      $display("FAIL rmw_recover got d=%h lat=%0d want 01020304 lat=%0d",
               obs.rdata, obs.lat, L + 2);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_b = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_load_word();
    test_subword_store();
    test_load_ext();
    test_misaligned();
    test_back_to_back();
    test_reset_rmw();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
